// File: rtl/vga_pkg.sv
// Shared definitions for the VGA streaming timing block: state encoding,
// counter width and default 640x480 timing.
package vga_pkg;

   typedef enum logic {
      WAIT_FILL = 1'b0,
      RUN       = 1'b1
   } vga_state_e;

   localparam int CNT_W = 11;

   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   function automatic int total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Horizontal/vertical raster counters with active-area and sync-window decode.
// Counters are held at zero whenever i_run is low.
module vga_sync_counter
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_run,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt,
   output logic             o_active,
   output logic             o_hsync,
   output logic             o_vsync
);

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (!i_run) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (r_h_cnt == H_LAST) begin
         r_h_cnt <= '0;
         r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
      end else begin
         r_h_cnt <= r_h_cnt + 1'b1;
      end
   end

   assign o_h_cnt  = r_h_cnt;
   assign o_v_cnt  = r_v_cnt;
   assign o_active = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
   assign o_hsync  = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
   assign o_vsync  = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

endmodule

// File: rtl/vga_stream_timing.sv
// VGA timing generator pulling pixels from a show-ahead FIFO, with one-stage output
// alignment and sticky underflow. Define VGA_UNDERFLOW_COUNT_EN to add underflow_count.
module vga_stream_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int COLOR_W  = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3*COLOR_W-1:0] fifo_data,
   input  logic                 fifo_empty,
   input  logic                 fifo_full,
   output logic                 fifo_rd_en,
   output logic [COLOR_W-1:0]   out_red,
   output logic [COLOR_W-1:0]   out_green,
   output logic [COLOR_W-1:0]   out_blue,
   output logic                 hs,
   output logic                 vs,
   output logic                 blank_n,
   output logic [CNT_W-1:0]     out_x,
   output logic [CNT_W-1:0]     out_y,
   output logic                 frame_start,
   output logic                 vblank_start,
   output logic                 underflow,
`ifdef VGA_UNDERFLOW_COUNT_EN
   output logic [15:0]          underflow_count,
`endif
   input  logic                 clr_underflow
);

   localparam logic [CNT_W-1:0] V_VBLANK = CNT_W'(V_ACTIVE);

   vga_state_e       r_state;
   logic [CNT_W-1:0] w_h_cnt;
   logic [CNT_W-1:0] w_v_cnt;
   logic             w_active;
   logic             w_hsync;
   logic             w_vsync;
   logic             w_run;
   logic             w_need_px;
   logic             w_underflow_px;

   vga_sync_counter #(
      .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
      .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
   ) u_sync_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_run    (w_run),
      .o_h_cnt  (w_h_cnt),
      .o_v_cnt  (w_v_cnt),
      .o_active (w_active),
      .o_hsync  (w_hsync),
      .o_vsync  (w_vsync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= WAIT_FILL;
      end else if (r_state == WAIT_FILL && fifo_full) begin
         r_state <= RUN;
      end
   end

   assign w_run          = (r_state == RUN);
   assign w_need_px      = w_run && w_active;
   // NOTE: rd_en is decoded from live fifo_empty; registering it would read a stale empty flag.
   assign fifo_rd_en     = w_need_px && !fifo_empty;
   assign w_underflow_px = w_need_px && fifo_empty;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_red      <= '0;
         out_green    <= '0;
         out_blue     <= '0;
         hs           <= ~HS_POL;
         vs           <= ~VS_POL;
         blank_n      <= 1'b0;
         out_x        <= '0;
         out_y        <= '0;
         frame_start  <= 1'b0;
         vblank_start <= 1'b0;
         underflow    <= 1'b0;
      end else begin
         {out_red, out_green, out_blue} <= fifo_rd_en ? fifo_data : '0;
         hs           <= (w_run && w_hsync) ? HS_POL : ~HS_POL;
         vs           <= (w_run && w_vsync) ? VS_POL : ~VS_POL;
         blank_n      <= w_need_px;
         out_x        <= w_need_px ? w_h_cnt : '0;
         out_y        <= w_need_px ? w_v_cnt : '0;
         frame_start  <= w_run && (w_h_cnt == '0) && (w_v_cnt == '0);
         vblank_start <= w_run && (w_h_cnt == '0) && (w_v_cnt == V_VBLANK);
         // A new underflow wins over a simultaneous clear.
         underflow    <= w_underflow_px | (underflow & ~clr_underflow);
      end
   end

`ifdef VGA_UNDERFLOW_COUNT_EN
   logic [15:0] r_underflow_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_underflow_count <= '0;
      end else if (clr_underflow) begin
         r_underflow_count <= w_underflow_px ? 16'd1 : 16'd0;
      end else if (w_underflow_px && r_underflow_count != 16'hFFFF) begin
         r_underflow_count <= r_underflow_count + 16'd1;
      end
   end

   assign underflow_count = r_underflow_count;
`endif

endmodule

// File: doc/vga_stream_timing.md
VGA_STREAM_TIMING -- requirements
Module: vga_stream_timing

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal porch and sync widths in clocks.
REQ-003 SHALL have parameter V_ACTIVE, default 480, visible lines.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical porch and sync widths in lines.
REQ-005 SHALL have parameters HS_POL/VS_POL, default 0/0, active level of hs/vs.
REQ-006 SHALL have parameter COLOR_W, default 8, bits per colour channel.
REQ-007 SHALL have ports: clk in 1 pixel clock; rst_n in 1 reset, asynchronous, active-low.
REQ-008 SHALL have ports: fifo_data in 3*COLOR_W {R,G,B}; fifo_empty in 1; fifo_full in 1; fifo_rd_en out 1.
REQ-009 SHALL have ports: out_red/out_green/out_blue out COLOR_W each; hs out 1; vs out 1; blank_n out 1.
REQ-010 SHALL have ports: out_x out 11; out_y out 11; frame_start out 1; vblank_start out 1; underflow out 1 (sticky).
REQ-011 SHALL have port clr_underflow in 1, synchronous clear of the sticky flag.

Function
REQ-012 SHALL keep h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1, H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, likewise V_TOTAL; h_cnt wraps to 0 and increments v_cnt, and v_cnt wraps to 0 after V_TOTAL-1.
REQ-013 SHALL implement states WAIT_FILL, RUN: WAIT_FILL holds counters at 0, blank_n=0, fifo_rd_en=0, and moves to RUN on the first cycle fifo_full=1.
REQ-014 In RUN, SHALL assert fifo_rd_en one clock before each active pixel (h_cnt<H_ACTIVE and v_cnt<V_ACTIVE on the following clock) and only when fifo_empty=0.
REQ-015 SHALL register colour outputs one clock after fifo_rd_en, with hs/vs/blank_n/out_x/out_y delayed to align exactly with that pixel.
REQ-016 SHALL drive blank_n=1 only for active pixels; blanked pixels output colour 0.
REQ-017 SHALL assert hs for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] at level HS_POL; vs likewise on v_cnt at level VS_POL.
REQ-018 Underflow (read required while fifo_empty=1) SHALL skip the read, output colour 0 for that pixel with blank_n=1, set underflow, and keep timing running.
REQ-019 SHALL pulse frame_start for one clock at h_cnt=0, v_cnt=0 in RUN, and pulse vblank_start for one clock at h_cnt=0, v_cnt=V_ACTIVE.
REQ-020 If clr_underflow and a new underflow coincide, the flag SHALL remain set.
REQ-021 SHALL present out_x/out_y as the aligned pixel's coordinates during active video and 0 otherwise.

Reset
REQ-022 rst_n low SHALL asynchronously force state WAIT_FILL, counters 0, all outputs 0 except hs=~HS_POL and vs=~VS_POL.
REQ-023 Reset mid-frame SHALL abandon the frame; after release, the block SHALL wait for fifo_full again.

Configuration
REQ-024 With VGA_UNDERFLOW_COUNT_EN defined, SHALL add output underflow_count (16 bits), incremented per underflow pixel, saturating at 0xFFFF, and cleared by clr_underflow.
REQ-025 Without VGA_UNDERFLOW_COUNT_EN, the port and counter SHALL be absent; all other behaviour SHALL be unchanged.

Structure
REQ-026 Shared package vga_pkg SHALL hold the state enum and default 640x480 timing constants.
REQ-027 Sub-module vga_sync_counter SHALL own h/v counters and sync and active decode; the top holds the FSM, FIFO handshake and alignment pipeline.

Verification
REQ-028 Defaults, fifo_full held low for 1000 clocks -> fifo_rd_en=0, blank_n=0 throughout; raise fifo_full -> first rd_en within 1 clock.
REQ-029 Always-non-empty FIFO delivering incrementing data -> exactly 640*480 reads per frame; pixel (0,0) colour equals first word; hs low 96 clocks at h_cnt 656..751.
REQ-030 fifo_empty forced high for pixels x=100..103 on line 5 -> those pixels black with blank_n=1, underflow=1, no rd_en; with macro, count=4.
REQ-031 Small params (H_ACTIVE=8, porches 1/2/1, V_ACTIVE=4, 1/1/1) -> H_TOTAL=12, V_TOTAL=7; frame_start every 84 clocks; vblank_start at v_cnt=4.
REQ-032 rst_n pulsed low at mid-line 200 -> outputs reset immediately; restart only after fifo_full; first frame_start aligned to h=0, v=0.
REQ-033 clr_underflow asserted in the same cycle as an underflow -> flag stays 1; next cycle clear with no underflow -> flag 0.
